// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR memory interface: bus-sink registers plus a req/ready handshake that returns R.
// Optional LC3_MEM_TIMEOUT_EN abandons an access after TIMEOUT_CYCLES wait cycles and sets sticky mem_err.
module lc3_mem_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_bus_in,
  output logic [15:0] mdr_bus,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        gate_mdr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        ready_r,
  output logic [15:0] mar,
  output logic [15:0] mdr,
  output logic        mem_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("lc3_mem_if: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [15:0] mar_q, mdr_q;
  logic        req_q, we_q, rdy_q, hold_q;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      hold_q  <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      cnt_q   <= 16'h0000;
      err_q   <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_mar) mar_q <= data_bus_in;
          if (ld_mdr && !mio_en) mdr_q <= data_bus_in;
          // hold keeps a still-asserted mio_en from re-triggering after R
          if (!mio_en) begin
            hold_q <= 1'b0;
          end else if (!hold_q) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            we_q    <= r_w;
`ifdef LC3_MEM_TIMEOUT_EN
            cnt_q   <= 16'h0000;
`endif
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b1;
            if (!we_q) mdr_q <= mem_rdata;
          end
`ifdef LC3_MEM_TIMEOUT_EN
          else if (cnt_q == TMO_LAST) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            if (!we_q) mdr_q <= 16'h0000;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        DONE: begin
          hold_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign ready_r   = rdy_q;
  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign mdr_bus   = gate_mdr ? mdr_q : 16'bz;

`ifdef LC3_MEM_TIMEOUT_EN
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_if.sv
// Self-checking bench for lc3_mem_if: behavioural memory responder plus a reference memory image
// that predicts MDR after reads; handshake timing is checked against the documented latencies.
module tb_lc3_mem_if;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_bus_in;
  wire  [15:0] mdr_bus;
  logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
  logic        mem_req, mem_we, mem_ready, ready_r, mem_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, mar, mdr;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  int ws   = 0;
  int wcnt = 0;

  lc3_mem_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .data_bus_in(data_bus_in), .mdr_bus(mdr_bus),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w), .gate_mdr(gate_mdr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ready_r(ready_r),
    .mar(mar), .mdr(mdr), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Memory: answers after ws wait cycles; outside a request mem_ready is random noise.
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (wcnt >= ws) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[7:0]];
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
        wcnt++;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      wcnt = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_access(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                           input int waits, input bit keep_mio, input bit poke_busy, input int ncyc,
                           output int lat, output int npulse, output int reqcyc, output bit stable);
    data_bus_in = addr; ld_mar = 1'b1;
    @(posedge clk); #1;
    ld_mar = 1'b0;
    if (we) begin
      data_bus_in = wd; ld_mdr = 1'b1;
      @(posedge clk); #1;
      ld_mdr = 1'b0;
    end
    ws = waits; mio_en = 1'b1; r_w = we; data_bus_in = 16'($urandom);
    @(posedge clk); #1;
    if (!keep_mio) mio_en = 1'b0;
    r_w = 1'($urandom);
    lat = 0; npulse = 0; reqcyc = 0; stable = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      if (poke_busy && c == 1) begin
        ld_mar = 1'b1; ld_mdr = 1'b1; data_bus_in = 16'hFFFF;
      end else begin
        ld_mar = 1'b0; ld_mdr = 1'b0;
      end
      if (mem_req === 1'b1) begin
        reqcyc++;
        if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wd)) stable = 1'b0;
      end
      if (ready_r === 1'b1) begin
        npulse++;
        if (lat == 0) lat = c;
      end
      @(posedge clk); #1;
    end
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; data_bus_in = 16'hFFFF; ld_mar = 1'b1; ld_mdr = 1'b1; mio_en = 1'b1;
    r_w = 1'b0; gate_mdr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; data_bus_in = 16'h0000;
    @(posedge clk); #1;
    nvec++; if (mar !== 16'h0000) begin nerr++; $display("FAIL reset_mar: got %h want 0000", mar); end
    nvec++; if (mdr !== 16'h0000) begin nerr++; $display("FAIL reset_mdr: got %h want 0000", mdr); end
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b want 0", mem_req); end
    nvec++; if (ready_r !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b want 0", ready_r); end
    nvec++; if (mem_err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", mem_err); end
  endtask

  task automatic test_read_zero_wait;
    int lat, np, rc; bit st;
    mem[8'h00] = 16'h1234; ref_mem[8'h00] = 16'h1234;
    do_access(1'b0, 16'h3000, 16'h0000, 0, 1'b0, 1'b0, 6, lat, np, rc, st);
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL rd0_latency: got %0d want 2", lat); end
    nvec++; if (np !== 1) begin nerr++; $display("FAIL rd0_pulses: got %0d want 1", np); end
    nvec++; if (rc !== 1) begin nerr++; $display("FAIL rd0_req_cycles: got %0d want 1", rc); end
    nvec++; if (st !== 1'b1) begin nerr++; $display("FAIL rd0_addr_stable: got %b want 1", st); end
    nvec++; if (mdr !== 16'h1234) begin nerr++; $display("FAIL rd0_mdr: got %h want 1234", mdr); end
    gate_mdr = 1'b1; #1;
    nvec++; if (mdr_bus !== 16'h1234) begin nerr++; $display("FAIL rd0_mdr_bus: got %h want 1234", mdr_bus); end
    gate_mdr = 1'b0;
  endtask

  task automatic test_write_wait;
    int lat, np, rc; bit st;
    do_access(1'b1, 16'h4000, 16'hBEEF, 3, 1'b0, 1'b1, 10, lat, np, rc, st);
    ref_mem[8'h00] = 16'hBEEF;
    nvec++; if (rc !== 4) begin nerr++; $display("FAIL wr3_req_cycles: got %0d want 4", rc); end
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL wr3_latency: got %0d want 5", lat); end
    nvec++; if (np !== 1) begin nerr++; $display("FAIL wr3_pulses: got %0d want 1", np); end
    nvec++; if (st !== 1'b1) begin nerr++; $display("FAIL wr3_stable: got %b want 1", st); end
    nvec++; if (mar !== 16'h4000) begin nerr++; $display("FAIL wr3_mar_busy_ld: got %h want 4000", mar); end
    nvec++; if (mdr !== 16'hBEEF) begin nerr++; $display("FAIL wr3_mdr_busy_ld: got %h want beef", mdr); end
    nvec++; if (mem[8'h00] !== 16'hBEEF) begin nerr++; $display("FAIL wr3_mem: got %h want beef", mem[8'h00]); end
  endtask

  task automatic test_random;
    int lat, np, rc; bit st;
    for (int i = 0; i < 40; i++) begin
      bit we = 1'($urandom);
      logic [15:0] a = 16'($urandom);
      logic [15:0] d = 16'($urandom);
      int w = $urandom_range(0, 5);
      do_access(we, a, d, w, 1'b0, 1'($urandom), w + 6, lat, np, rc, st);
      if (we) ref_mem[a[7:0]] = d;
      nvec++; if (lat !== w + 2) begin nerr++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, w + 2); end
      nvec++; if (np !== 1) begin nerr++; $display("FAIL rnd%0d_pulses: got %0d want 1", i, np); end
      nvec++; if (rc !== w + 1) begin nerr++; $display("FAIL rnd%0d_req_cycles: got %0d want %0d", i, rc, w + 1); end
      nvec++; if (st !== 1'b1) begin nerr++; $display("FAIL rnd%0d_stable: got %b want 1", i, st); end
      nvec++; if (mar !== a) begin nerr++; $display("FAIL rnd%0d_mar: got %h want %h", i, mar, a); end
      nvec++;
      if (mdr !== (we ? d : ref_mem[a[7:0]])) begin
        nerr++; $display("FAIL rnd%0d_mdr: got %h want %h", i, mdr, we ? d : ref_mem[a[7:0]]);
      end
    end
  endtask

  task automatic test_hold;
    int lat, np, rc, bound; bit st;
    do_access(1'b0, 16'h0042, 16'h0000, 1, 1'b1, 1'b0, 9, lat, np, rc, st);
    nvec++; if (np !== 1) begin nerr++; $display("FAIL hold_pulses: got %0d want 1", np); end
    nvec++; if (rc !== 2) begin nerr++; $display("FAIL hold_req_cycles: got %0d want 2", rc); end
    nvec++; if (mdr !== ref_mem[8'h42]) begin nerr++; $display("FAIL hold_mdr: got %h want %h", mdr, ref_mem[8'h42]); end
    // do_access drops mio_en on return: one low cycle, then re-raise
    @(posedge clk); #1;
    mio_en = 1'b1; r_w = 1'b0;
    @(posedge clk); #1;
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL hold_rearm_req: got %b want 1", mem_req); end
    bound = 0;
    while (ready_r !== 1'b1 && bound < 20) begin @(posedge clk); #1; bound++; end
    nvec++; if (ready_r !== 1'b1) begin nerr++; $display("FAIL hold_rearm_ready: timed out after %0d cycles", bound); end
    mio_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int np = 0, rc = 0;
    data_bus_in = 16'hA5A5; ld_mdr = 1'b1;
    @(posedge clk); #1;
    ld_mdr = 1'b0;
    nvec++; if (mdr !== 16'hA5A5) begin nerr++; $display("FAIL rstmid_mdr_load: got %h want a5a5", mdr); end
    data_bus_in = 16'h1111; ld_mar = 1'b1;
    @(posedge clk); #1;
    ld_mar = 1'b0; ws = 20; mio_en = 1'b1; r_w = 1'b0;
    @(posedge clk); #1;
    mio_en = 1'b0;
    @(posedge clk); #1;
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL rstmid_busy2_req: got %b want 1", mem_req); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rstmid_req: got %b want 0", mem_req); end
    nvec++; if (mdr !== 16'h0000) begin nerr++; $display("FAIL rstmid_mdr: got %h want 0000", mdr); end
    nvec++; if (mar !== 16'h0000) begin nerr++; $display("FAIL rstmid_mar: got %h want 0000", mar); end
    for (int c = 0; c < 6; c++) begin
      if (ready_r === 1'b1) np++;
      if (mem_req === 1'b1) rc++;
      @(posedge clk); #1;
    end
    nvec++; if (np !== 0) begin nerr++; $display("FAIL rstmid_no_ready: got %0d pulses want 0", np); end
    nvec++; if (rc !== 0) begin nerr++; $display("FAIL rstmid_no_req: got %0d cycles want 0", rc); end
  endtask

  task automatic test_timeout;
    int lat, np, rc; bit st;
    data_bus_in = 16'h5A5A; ld_mdr = 1'b1;
    @(posedge clk); #1;
    ld_mdr = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
    do_access(1'b0, 16'h0022, 16'h0000, 1000, 1'b0, 1'b0, 12, lat, np, rc, st);
    nvec++; if (rc !== TMO) begin nerr++; $display("FAIL tmo_req_cycles: got %0d want %0d", rc, TMO); end
    nvec++; if (lat !== TMO + 1) begin nerr++; $display("FAIL tmo_latency: got %0d want %0d", lat, TMO + 1); end
    nvec++; if (np !== 1) begin nerr++; $display("FAIL tmo_pulses: got %0d want 1", np); end
    nvec++; if (mem_err !== 1'b1) begin nerr++; $display("FAIL tmo_err: got %b want 1", mem_err); end
    nvec++; if (mdr !== 16'h0000) begin nerr++; $display("FAIL tmo_mdr: got %h want 0000", mdr); end
    do_access(1'b0, 16'h0033, 16'h0000, 0, 1'b0, 1'b0, 6, lat, np, rc, st);
    nvec++; if (mem_err !== 1'b1) begin nerr++; $display("FAIL tmo_err_sticky: got %b want 1", mem_err); end
    nvec++; if (mdr !== ref_mem[8'h33]) begin nerr++; $display("FAIL tmo_next_mdr: got %h want %h", mdr, ref_mem[8'h33]); end
`else
    do_access(1'b0, 16'h0022, 16'h0000, 1000, 1'b0, 1'b0, 30, lat, np, rc, st);
    nvec++; if (rc !== 30) begin nerr++; $display("FAIL notmo_req_held: got %0d cycles want 30", rc); end
    nvec++; if (np !== 0) begin nerr++; $display("FAIL notmo_pulses: got %0d want 0", np); end
    nvec++; if (mem_err !== 1'b0) begin nerr++; $display("FAIL notmo_err: got %b want 0", mem_err); end
    nvec++; if (mdr !== 16'h5A5A) begin nerr++; $display("FAIL notmo_mdr: got %h want 5a5a", mdr); end
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nvec++; if (mem_err !== 1'b0) begin nerr++; $display("FAIL tmo_err_reset: got %b want 0", mem_err); end
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL tmo_req_reset: got %b want 0", mem_req); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_read_zero_wait;
    test_write_wait;
    test_random;
    test_hold;
    test_reset_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lc3_mem_if.md
Name: lc3_mem_if

Overview:
MAR/MDR memory interface for the LC-3 datapath. It is the bus-sink side of the gated datapath bus. It loads MAR and MDR from data_bus and runs a request/ready handshake with memory on MIO.EN. It returns the R (ready) signal to the control FSM and drives MDR back onto data_bus through a tri-state gate under gate_mdr.

Parameters:
TIMEOUT_CYCLES, 255, wait cycles before an access is abandoned (used only when LC3_MEM_TIMEOUT_EN is defined); legal range 1..65535.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
data_bus_in  input  16  datapath bus value as seen by MAR/MDR
mdr_bus  output  16  MDR driven onto datapath bus; 16'bz when gate_mdr=0
ld_mar  input  1  load MAR from data_bus_in
ld_mdr  input  1  load MDR from data_bus_in (only when mio_en=0)
mio_en  input  1  memory access enable from control FSM
r_w  input  1  1 = write, 0 = read; sampled at access start
gate_mdr  input  1  drive MDR onto mdr_bus
mem_req  output  1  memory request, held until accepted
mem_we  output  1  write strobe qualifier for mem_req
mem_addr  output  16  equals MAR register
mem_wdata  output  16  equals MDR register
mem_rdata  input  16  read data, valid with mem_ready on reads
mem_ready  input  1  memory completion
ready_r  output  1  one-cycle R pulse to control FSM
mar  output  16  MAR register, for debug
mdr  output  16  MDR register, for debug
mem_err  output  1  sticky timeout flag; constant 0 without the feature

Behaviour:
- Reset values: MAR=x0000, MDR=x0000, state=IDLE, mem_req=0, mem_we=0, ready_r=0, mem_err=0, hold=0. Reset wins over every other input.
- Reset mid-access: mem_req drops at that edge and the access is discarded with no ready_r pulse.
- States and transitions:
  - IDLE:
    - mio_en=1 and hold=0: go to BUSY at the edge. Latch mem_we<=r_w. mem_req=1 from the next cycle.
    - mio_en=0: clear hold.
  - BUSY:
    - mem_req=1. mem_addr, mem_wdata and mem_we are held stable.
    - Stay in BUSY while mem_ready=0.
    - mem_ready=1 sampled: go to DONE. On a read, MDR<=mem_rdata. mem_req=0 from the next cycle.
  - DONE:
    - ready_r=1 for exactly this one cycle. Set hold=1. Go to IDLE.
- hold blocks a second access while the control FSM still asserts mio_en after R. A new access needs mio_en low for at least one cycle.
- mem_ready is ignored outside BUSY.
- Zero-wait memory (mem_ready=1 in the first BUSY cycle) is legal. Minimum latency: mio_en sampled at edge N, mem_req high in cycle N+1, ready_r high in cycle N+2.
- Dropping mio_en during BUSY does not abort the access, and the R pulse still occurs.
- MAR:
  - ld_mar=1 in IDLE: MAR<=data_bus_in.
  - ld_mar in BUSY or DONE is ignored.
  - ld_mar in the same cycle that starts an access: the new MAR value is the access address.
- MDR:
  - ld_mdr=1 with mio_en=0 in IDLE: MDR<=data_bus_in.
  - ld_mdr with mio_en=1 never loads from the bus.
  - ld_mdr in BUSY or DONE is ignored.
  - ld_mdr in the same cycle that starts a write: the new MDR value is written.
- mdr_bus is purely combinational: MDR when gate_mdr=1, else 16'bz. Gating is independent of state; a read's MDR value is gateable from cycle N+2 onward.
- All widths are 16 bits. There is no arithmetic and no wrap-around.

Optional Feature:
LC3_MEM_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to BUSY and increments each BUSY cycle with mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with mem_req dropped and set mem_err=1.
  - On a read, MDR<=x0000.
  - ready_r pulses as normal.
  - mem_err is cleared only by reset.
  - mem_ready in the same cycle as the count reaching TIMEOUT_CYCLES: mem_ready wins and mem_err stays 0.
- Not defined: BUSY waits indefinitely, mem_err is tied 0, and no counter is built.

Test Plan:
- Reset then idle -> mar=x0000, mdr=x0000, mem_req=0, ready_r=0, mdr_bus=z.
- Read with 0 wait states: data_bus_in=x3000 with ld_mar; mio_en=1, r_w=0; memory returns x1234 with mem_ready in the first BUSY cycle -> mem_addr=x3000, ready_r pulses once 2 cycles after mio_en, mdr=x1234, mdr_bus=x1234 under gate_mdr.
- Write with 3 wait states: ld_mar x4000, ld_mdr xBEEF, mio_en=1, r_w=1 -> mem_req/mem_we high 4 cycles with mem_addr=x4000 and mem_wdata=xBEEF stable; a single ready_r pulse; ld_mar xFFFF applied during BUSY leaves mar at x4000.
- mio_en held high 5 cycles past R -> exactly one access. Dropping mio_en for 1 cycle then raising it -> a second access starts.
- Reset asserted in the 2nd BUSY cycle of a read -> mem_req=0 next cycle, no ready_r, mdr=x0000.
- With LC3_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, read with mem_ready never asserted -> ready_r after the timeout, mem_err=1 and sticky, mdr=x0000. Without the macro, the same stimulus keeps mem_req high indefinitely and mem_err=0.
